mul_sequencer: RTL and testbench

- Multi-cycle controller executing ARM MUL/MLA (low 32 bits of product) by sequencing the shared combinational ALU in ADD mode, radix-2 shift-add.
- Sits in the EXE stage beside the ALU. While active it owns the ALU operand/command lines (alu_grant=1) and stalls the pipeline.
- On completion it returns the result and, for S-suffixed ops, a status update for the status register.

---
 rtl/mul_sequencer_pkg.sv | 23 ++
 rtl/mul_sequencer.sv | 155 +++++++++++++++
 tb/tb_mul_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mul_sequencer_pkg.sv
// Shared definitions for the MUL/MLA sequencer: the ALU ADD command it
// issues and its state encodings.
package mul_sequencer_pkg;

  // Shared ALU command encoding: ARM data-processing opcode for ADD.
  localparam logic [3:0] ALU_CMD_ADD = 4'b0100;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_ITER = 2'd1,
    MUL_ACC  = 2'd2,
    MUL_DONE = 2'd3
  } mul_state_e;

  // Status register layout {Z,C,N,V}.
  typedef struct packed {
    logic z;
    logic c;
    logic n;
    logic v;
  } status_t;

endpackage : mul_sequencer_pkg

// File: rtl/mul_sequencer.sv
// Multi-cycle MUL/MLA controller: radix-2 shift-add using the shared ALU in
// ADD mode, optional accumulate, and status update on completion.
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mla,
  input  logic             s_flag,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] acc,
  input  logic [3:0]       status_in,
  input  logic [WIDTH-1:0] alu_res,
  output logic [WIDTH-1:0] alu_val1,
  output logic [WIDTH-1:0] alu_val2,
  output logic [3:0]       alu_cmd,
  output logic             alu_grant,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       status_out,
  output logic             status_we
);

  mul_state_e state, next_state;

  logic [WIDTH-1:0] m_q;     // multiplicand, shifted left each iteration
  logic [WIDTH-1:0] q_q;     // multiplier, shifted right each iteration
  logic [WIDTH-1:0] p_q;     // partial product
  logic [WIDTH-1:0] acc_q;
  logic             mla_q;
  logic             s_q;
  status_t          status_lat;
  logic [WIDTH-1:0] p_next;
  logic             enter_done;
  status_t          status_new;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MUL_IDLE;
    else        state <= next_state;
  end

  // Next-state logic. Iteration stops once the remaining multiplier bits
  // are all zero, so the count tracks the MSB position of op_b.
  // NOTE: every combinational output gets a default first so no path
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      MUL_IDLE: if (start) next_state = MUL_ITER;
      MUL_ITER: if ((q_q >> 1) == '0) next_state = mla_q ? MUL_ACC : MUL_DONE;
      MUL_ACC:  next_state = MUL_DONE;
      MUL_DONE: next_state = MUL_IDLE;
      default:  next_state = MUL_IDLE;
    endcase
  end

  // Partial product after this cycle's ALU pass.
  always_comb begin
    p_next = p_q;
    if ((state == MUL_ITER && q_q[0]) || state == MUL_ACC) p_next = alu_res;
  end

  // Result and status are loaded on entry to DONE so they are already
  // valid while done/status_we pulse.
  assign enter_done = (next_state == MUL_DONE) && (state != MUL_DONE);

  always_comb begin
    status_new   = status_lat;
    status_new.z = (p_next == '0);
    status_new.n = p_next[WIDTH-1];
  end

  // Operand and partial-product datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q        <= '0;
      q_q        <= '0;
      p_q        <= '0;
      acc_q      <= '0;
      mla_q      <= 1'b0;
      s_q        <= 1'b0;
      status_lat <= '0;
    end else begin
      unique case (state)
        MUL_IDLE: if (start) begin
          m_q        <= op_a;
          q_q        <= op_b;
          acc_q      <= acc;
          mla_q      <= mla;
          s_q        <= s_flag;
          status_lat <= status_t'(status_in);
          p_q        <= '0;
        end
        MUL_ITER: begin
          m_q <= m_q << 1;
          q_q <= q_q >> 1;
          p_q <= p_next;
        end
        MUL_ACC:  p_q <= p_next;
        default:  ;
      endcase
    end
  end

  // Architectural outputs held between operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result     <= '0;
      status_out <= '0;
    end else if (enter_done) begin
      result <= p_next;
      if (s_q) status_out <= status_new;
    end
  end

  // Output decode straight from the state register and datapath flops.
  always_comb begin
    alu_grant = 1'b0;
    alu_val1  = '0;
    alu_val2  = '0;
    busy      = (state != MUL_IDLE);
    done      = 1'b0;
    status_we = 1'b0;
    unique case (state)
      MUL_ITER: begin
        alu_grant = 1'b1;
        alu_val1  = p_q;
        alu_val2  = m_q;
      end
      MUL_ACC: begin
        alu_grant = 1'b1;
        alu_val1  = p_q;
        alu_val2  = acc_q;
      end
      MUL_DONE: begin
        done      = 1'b1;
        status_we = s_q;
      end
      default: ;
    endcase
  end

  assign stall   = busy;
  assign alu_cmd = ALU_CMD_ADD;

endmodule : mul_sequencer

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer with a behavioural ADD-only ALU model.
module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, mla, s_flag;
  logic [31:0] op_a, op_b, acc, alu_res, alu_val1, alu_val2, result;
  logic [3:0]  status_in, alu_cmd, status_out;
  logic        alu_grant, busy, stall, done, status_we;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Shared ALU: only the ADD command produces a sum.
  assign alu_res = (alu_cmd == 4'b0100) ? alu_val1 + alu_val2 : 32'hDEAD_BEEF;

  mul_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mla(mla), .s_flag(s_flag),
    .op_a(op_a), .op_b(op_b), .acc(acc), .status_in(status_in),
    .alu_res(alu_res), .alu_val1(alu_val1), .alu_val2(alu_val2),
    .alu_cmd(alu_cmd), .alu_grant(alu_grant), .busy(busy), .stall(stall),
    .done(done), .result(result), .status_out(status_out),
    .status_we(status_we)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a, b, acc_v;
    logic        mla_v, s_v;
    logic [3:0]  st_in;
    logic [31:0] res;
    int          lat;
    int          grants;
    logic [3:0]  st_out;
    logic        we;
  } vec_t;

  vec_t vecs[9];

  // Launch from IDLE: inputs set away from the edge, accepted at the next edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic m, input logic s, input logic [3:0] st, input logic hold);
    @(posedge clk); #1;
    op_a = a; op_b = b; acc = c; mla = m; s_flag = s; status_in = st; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
  endtask

  // Count cycles after the accepting edge until done, bounded.
  task automatic wait_done(output int lat, output int grants, output bit busy_ok,
                           output int dones);
    lat = 0; grants = 0; busy_ok = 1'b1; dones = 0;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (!busy || stall !== busy) busy_ok = 1'b0;
      if (alu_grant) grants++;
      if (done) begin
        dones++;
        break;
      end
    end
    if (dones == 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lat, grants, dones;
    bit busy_ok;
    logic [31:0] old_res;

    vecs[0] = '{32'd7, 32'd6, 32'd0, 1'b0, 1'b0, 4'b0000, 32'd42, 4, 3, 4'b0000, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'd2, 32'd3, 1'b1, 1'b1, 4'b0110, 32'd1, 4, 3, 4'b0100, 1'b1};
    vecs[2] = '{32'd5, 32'd0, 32'd0, 1'b0, 1'b1, 4'b1011, 32'd0, 2, 1, 4'b1001, 1'b1};
    vecs[3] = '{32'h8000_0000, 32'd2, 32'd0, 1'b0, 1'b1, 4'b0000, 32'd0, 3, 2, 4'b1000, 1'b1};
    vecs[4] = '{32'd3, 32'h8000_0001, 32'd5, 1'b1, 1'b0, 4'b1111, 32'h8000_0008, 34, 33, 4'b1000, 1'b0};
    vecs[5] = '{32'h1234_5678, 32'd1, 32'd0, 1'b0, 1'b1, 4'b0000, 32'h1234_5678, 2, 1, 4'b0000, 1'b1};
    vecs[6] = '{32'h0001_0000, 32'h0001_0000, 32'd7, 1'b1, 1'b1, 4'b0101, 32'd7, 19, 18, 4'b0101, 1'b1};
    vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 4'b0000, 32'd1, 33, 32, 4'b0000, 1'b1};
    vecs[8] = '{32'd2, 32'h4000_0000, 32'd0, 1'b0, 1'b1, 4'b0000, 32'h8000_0000, 32, 31, 4'b0010, 1'b1};

    rst_n = 1'b0; start = 1'b0; mla = 1'b0; s_flag = 1'b0;
    op_a = '0; op_b = '0; acc = '0; status_in = '0;
    #2;
    check("rst_busy",   {31'd0, busy},      32'd0);
    check("rst_stall",  {31'd0, stall},     32'd0);
    check("rst_done",   {31'd0, done},      32'd0);
    check("rst_grant",  {31'd0, alu_grant}, 32'd0);
    check("rst_we",     {31'd0, status_we}, 32'd0);
    check("rst_result", result,             32'd0);
    check("rst_status", {28'd0, status_out}, 32'd0);
    check("rst_val1",   alu_val1,           32'd0);
    check("rst_val2",   alu_val2,           32'd0);
    check("rst_cmd",    {28'd0, alu_cmd},   32'd4);
    #10 rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].acc_v, vecs[i].mla_v, vecs[i].s_v, vecs[i].st_in, 1'b0);
      wait_done(lat, grants, busy_ok, dones);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_result", i), result, vecs[i].res);
      check($sformatf("v%0d_status", i), {28'd0, status_out}, {28'd0, vecs[i].st_out});
      check($sformatf("v%0d_we", i), {31'd0, status_we}, {31'd0, vecs[i].we});
      check($sformatf("v%0d_grants", i), grants, vecs[i].grants);
      check($sformatf("v%0d_busy", i), {31'd0, busy_ok}, 32'd1);
      @(negedge clk);
      check($sformatf("v%0d_idle", i), {30'd0, busy, done}, 32'd0);
      check($sformatf("v%0d_hold", i), result, vecs[i].res);
    end

    // Result keeps the previous product until the next DONE.
    old_res = 32'h8000_0000;
    launch(32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 4'b0000, 1'b0);
    @(negedge clk);
    check("hold_old_result", result, old_res);
    check("hold_busy", {31'd0, busy}, 32'd1);
    wait_done(lat, grants, busy_ok, dones);
    check("hold_new_result", result, 32'd15);
    check("hold_latency", lat, 3);

    // start held high throughout: exactly one launch, normal latency.
    launch(32'd9, 32'd4, 32'd0, 1'b0, 1'b0, 4'b0000, 1'b1);
    wait_done(lat, grants, busy_ok, dones);
    check("held_latency", lat, 4);
    check("held_result", result, 32'd36);
    check("held_busy", {31'd0, busy_ok}, 32'd1);
    start = 1'b0;
    @(negedge clk);
    check("held_idle", {31'd0, busy}, 32'd0);

    // start raised during the DONE cycle is ignored.
    launch(32'd11, 32'd3, 32'd0, 1'b0, 1'b0, 4'b0000, 1'b0);
    wait_done(lat, grants, busy_ok, dones);
    check("dstart_result", result, 32'd33);
    op_a = 32'd2; op_b = 32'd2; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("dstart_ignored", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("dstart_still_idle", {31'd0, busy}, 32'd0);
    check("dstart_result_kept", result, 32'd33);

    // Asynchronous reset mid-ITER aborts without done or status_we.
    launch(32'd1, 32'h8000_0000, 32'd0, 1'b1, 1'b1, 4'b1111, 1'b0);
    repeat (5) @(negedge clk);
    check("mid_busy", {30'd0, busy, alu_grant}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy",   {29'd0, busy, stall, alu_grant}, 32'd0);
    check("arst_pulses", {30'd0, done, status_we}, 32'd0);
    check("arst_vals",   alu_val1 | alu_val2, 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_status", {28'd0, status_out}, 32'd0);
    repeat (2) @(negedge clk);
    check("arst_no_done", {30'd0, done, status_we}, 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("arst_idle", {31'd0, busy}, 32'd0);
    launch(32'd7, 32'd6, 32'd0, 1'b0, 1'b0, 4'b0000, 1'b0);
    wait_done(lat, grants, busy_ok, dones);
    check("recover_result", result, 32'd42);
    check("recover_latency", lat, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mul_sequencer
